regbank_wb_arbiter: RTL and testbench
=====================================

// Module: regbank_wb_arbiter
// PURPOSE
//  Write-back scheduler for the 16x16 register bank's single write port and PC-update path.
//  Accepts writes from two requesters (ALU result, memory load) and PC updates from the control unit.
//  Buffers each requester one entry deep and commits at most one bank operation per cycle.
//  Drives wr_en/wr_reg/wr_data and pc_inc/pc_data_in, which are never asserted together.
//  Keeps a pending-write scoreboard so the control unit can stall on read-after-write hazards.
// PARAMETERS
//  DW          16  data width
//  AW          4   register address width (2**AW registers)
//  PC_REG      0   register index holding the PC
//  STARVE_MAX  3   consecutive PC grants allowed while a data entry waits
// PORTS
//  clk         in   1   system clock; rising edge
//  rst         in   1   asynchronous, active-low reset
//  alu_vld     in   1   ALU write request
//  alu_rdy     out  1   ALU holding entry can accept
//  alu_reg     in   AW  ALU destination register
//  alu_data    in   DW  ALU result
//  ld_vld      in   1   load write request
//  ld_rdy      out  1   load holding entry can accept
//  ld_reg      in   AW  load destination register
//  ld_data     in   DW  load data
//  pc_req      in   1   control unit requests PC update (level)
//  pc_next     in   DW  new PC value
//  pc_gnt      out  1   1-cycle pulse: PC update committed this cycle
//  pc_drop     out  1   1-cycle pulse: pending PC update discarded (superseded)
//  src_reg     in   AW  bank read address A (hazard check)
//  dst_reg     in   AW  bank read address B (hazard check)
//  rd_hazard   out  1   src_reg or dst_reg has an uncommitted buffered write
//  busy        out  2**AW  per-register pending-write bits
//  wr_en       out  1   bank write enable (registered)
//  wr_reg      out  AW  bank write address (registered)
//  wr_data     out  DW  bank write data (registered)
//  pc_inc      out  1   bank PC-update strobe (registered)
//  pc_data_in  out  DW  PC value to bank (registered)
// BEHAVIOUR
//  Reset (rst=0, asynchronous): clear both holding entries, the age bit and the starve counter.
//   All outputs read 0, except alu_rdy=ld_rdy=1. Reset mid-transfer drops all buffered data.
//  Accept: X_vld & X_rdy at a clock edge loads the entry and sets busy[X_reg].
//   X_rdy = entry empty, or entry being committed this cycle (full-throughput refill).
//  Age: one bit marks which valid entry is older. Same-edge accepts make ALU older.
//  Each cycle, select at most one operation, in this priority order:
//   1. Any valid entry targeting PC_REG (oldest first): commit it; if pc_req=1, pulse pc_drop.
//   2. pc_req=1 and starve_cnt<STARVE_MAX (or no data entry valid): commit PC, pulse pc_gnt.
//   3. Oldest valid data entry: commit it and reset starve_cnt to 0.
//  starve_cnt increments on each PC grant while a data entry is valid, saturating at STARVE_MAX.
//   It clears when no data entry is valid.
//  Commit: on the next edge, drive wr_en=1 with wr_reg/wr_data, or pc_inc=1 with pc_data_in.
//   The entry empties and busy[reg] clears on the same edge (unless the other entry targets reg).
//   Latency is accept-edge to wr_en high = 1 cycle minimum; the bank writes on the following edge.
//  Strobes: wr_en and pc_inc are one-hot-or-zero every cycle; data and address hold last value when idle.
//  pc_req must stay high until pc_gnt or pc_drop. pc_gnt/pc_drop are asserted in the commit cycle.
//  Same-register entries always commit in age order (write-after-write order is preserved).
//  rd_hazard = busy[src_reg] | busy[dst_reg]. It is combinational from the registered busy bits.
// TESTING
//  rst low mid-transfer with both entries full -> wr_en=pc_inc=0, busy=0, alu_rdy=ld_rdy=1 immediately.
//  ALU r5=0x1234 alone -> next cycle wr_en=1, wr_reg=5, wr_data=0x1234; busy[5] 1 for 1 cycle.
//  Same-edge ALU r4=0x0001 and LD r4=0x0002 -> commits 0x0001 then 0x0002 on consecutive cycles; busy[4] clears after 2nd.
//  pc_req held high with LD r9 pending -> 3 pc_gnt pulses, then the r9 write, then pc_gnt resumes.
//  ALU r0=0x0100 while pc_req=1 (pc_next=0x0040) -> wr_en to r0 with 0x0100, pc_drop pulse, no pc_inc.
//  LD r7 buffered, src_reg=7 -> rd_hazard=1 until the wr_en cycle for r7, then 0.

Source files
------------

// File: rtl/regbank_wb_arbiter.sv
// Write-back scheduler for the register bank write port and PC-update path.
// Ports: alu_*/ld_* write requesters, pc_* update handshake, src/dst hazard
//   lookup, busy scoreboard, wr_*/pc_inc/pc_data_in registered bank strobes.
module regbank_wb_arbiter #(
  parameter int DW         = 16,
  parameter int AW         = 4,
  parameter int PC_REG     = 0,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_vld,
  output logic              alu_rdy,
  input  logic [AW-1:0]     alu_reg,
  input  logic [DW-1:0]     alu_data,
  input  logic              ld_vld,
  output logic              ld_rdy,
  input  logic [AW-1:0]     ld_reg,
  input  logic [DW-1:0]     ld_data,
  input  logic              pc_req,
  input  logic [DW-1:0]     pc_next,
  output logic              pc_gnt,
  output logic              pc_drop,
  input  logic [AW-1:0]     src_reg,
  input  logic [AW-1:0]     dst_reg,
  output logic              rd_hazard,
  output logic [(1<<AW)-1:0] busy,
  output logic              wr_en,
  output logic [AW-1:0]     wr_reg,
  output logic [DW-1:0]     wr_data,
  output logic              pc_inc,
  output logic [DW-1:0]     pc_data_in
);

  localparam int NR = 1 << AW;
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [AW-1:0] PCR = AW'(PC_REG);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

  logic          r_a_vld;
  logic [AW-1:0] r_a_reg;
  logic [DW-1:0] r_a_data;
  logic          r_l_vld;
  logic [AW-1:0] r_l_reg;
  logic [DW-1:0] r_l_data;
  // 1: ALU entry is the older one when both are valid
  logic          r_age;
  logic [SW-1:0] r_starve;
  logic [NR-1:0] r_busy;
  logic          r_wr_en;
  logic [AW-1:0] r_wr_reg;
  logic [DW-1:0] r_wr_data;
  logic          r_pc_inc;
  logic [DW-1:0] r_pc_data;

  logic          w_a_pc;
  logic          w_l_pc;
  logic          w_any;
  logic          w_a_old;
  logic          w_pc_pri;
  logic          w_pc_ok;
  logic          w_cm_a;
  logic          w_cm_l;
  logic          w_sel_pc;
  logic          w_cm_data;
  logic          w_acc_a;
  logic          w_acc_l;
  logic          w_a_nv;
  logic          w_l_nv;
  logic [AW-1:0] w_a_nreg;
  logic [AW-1:0] w_l_nreg;
  logic [AW-1:0] w_c_reg;
  logic [DW-1:0] w_c_data;
  logic          w_age_n;
  logic [SW-1:0] w_starve_n;
  logic [NR-1:0] w_busy_n;

  assign w_a_pc   = r_a_vld & (r_a_reg == PCR);
  assign w_l_pc   = r_l_vld & (r_l_reg == PCR);
  assign w_any    = r_a_vld | r_l_vld;
  assign w_a_old  = r_a_vld & (~r_l_vld | r_age);
  assign w_pc_pri = w_a_pc | w_l_pc;
  assign w_pc_ok  = pc_req & ((r_starve < SMAX) | ~w_any);

  always_comb begin
    w_cm_a   = 1'b0;
    w_cm_l   = 1'b0;
    w_sel_pc = 1'b0;
    priority case (1'b1)
      w_pc_pri: begin
        if (w_a_pc & (~w_l_pc | r_age)) w_cm_a = 1'b1;
        else w_cm_l = 1'b1;
      end
      w_pc_ok: w_sel_pc = 1'b1;
      w_any: begin
        if (w_a_old) w_cm_a = 1'b1;
        else w_cm_l = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_cm_data = w_cm_a | w_cm_l;
  assign w_c_reg   = w_cm_a ? r_a_reg : r_l_reg;
  assign w_c_data  = w_cm_a ? r_a_data : r_l_data;

  // refill allowed in the same cycle the entry drains
  assign alu_rdy = ~r_a_vld | w_cm_a;
  assign ld_rdy  = ~r_l_vld | w_cm_l;
  assign w_acc_a = alu_vld & alu_rdy;
  assign w_acc_l = ld_vld & ld_rdy;

  assign w_a_nv   = (r_a_vld & ~w_cm_a) | w_acc_a;
  assign w_l_nv   = (r_l_vld & ~w_cm_l) | w_acc_l;
  assign w_a_nreg = w_acc_a ? alu_reg : r_a_reg;
  assign w_l_nreg = w_acc_l ? ld_reg : r_l_reg;

  // a freshly loaded LD is younger; a lone fresh ALU is younger
  assign w_age_n = w_acc_l ? 1'b1 : (w_acc_a ? 1'b0 : r_age);

  always_comb begin
    w_busy_n = '0;
    if (w_a_nv) w_busy_n[w_a_nreg] = 1'b1;
    if (w_l_nv) w_busy_n[w_l_nreg] = 1'b1;
  end

  always_comb begin
    w_starve_n = r_starve;
    if (!w_any) w_starve_n = '0;
    else if (w_sel_pc) begin
      if (r_starve < SMAX) w_starve_n = r_starve + 1'b1;
    end else if (w_cm_data) w_starve_n = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a_vld   <= 1'b0;
      r_a_reg   <= '0;
      r_a_data  <= '0;
      r_l_vld   <= 1'b0;
      r_l_reg   <= '0;
      r_l_data  <= '0;
      r_age     <= 1'b0;
      r_starve  <= '0;
      r_busy    <= '0;
      r_wr_en   <= 1'b0;
      r_wr_reg  <= '0;
      r_wr_data <= '0;
      r_pc_inc  <= 1'b0;
      r_pc_data <= '0;
    end else begin
      r_a_vld  <= w_a_nv;
      r_l_vld  <= w_l_nv;
      r_age    <= w_age_n;
      r_starve <= w_starve_n;
      r_busy   <= w_busy_n;
      if (w_acc_a) begin
        r_a_reg  <= alu_reg;
        r_a_data <= alu_data;
      end
      if (w_acc_l) begin
        r_l_reg  <= ld_reg;
        r_l_data <= ld_data;
      end
      r_wr_en  <= w_cm_data;
      r_pc_inc <= w_sel_pc;
      if (w_cm_data) begin
        r_wr_reg  <= w_c_reg;
        r_wr_data <= w_c_data;
      end
      if (w_sel_pc) r_pc_data <= pc_next;
    end
  end

  assign pc_gnt     = w_sel_pc & rst;
  assign pc_drop    = w_pc_pri & pc_req & rst;
  assign busy       = r_busy;
  assign rd_hazard  = r_busy[src_reg] | r_busy[dst_reg];
  assign wr_en      = r_wr_en;
  assign wr_reg     = r_wr_reg;
  assign wr_data    = r_wr_data;
  assign pc_inc     = r_pc_inc;
  assign pc_data_in = r_pc_data;

endmodule

// File: tb/tb_regbank_wb_arbiter.sv
// Directed bench for regbank_wb_arbiter.
// One task per scenario with inline expected-value checks.
module tb_regbank_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        alu_vld;
  logic        alu_rdy;
  logic [3:0]  alu_reg;
  logic [15:0] alu_data;
  logic        ld_vld;
  logic        ld_rdy;
  logic [3:0]  ld_reg;
  logic [15:0] ld_data;
  logic        pc_req;
  logic [15:0] pc_next;
  logic        pc_gnt;
  logic        pc_drop;
  logic [3:0]  src_reg;
  logic [3:0]  dst_reg;
  logic        rd_hazard;
  logic [15:0] busy;
  logic        wr_en;
  logic [3:0]  wr_reg;
  logic [15:0] wr_data;
  logic        pc_inc;
  logic [15:0] pc_data_in;

  int n_chk;
  int n_fail;

  regbank_wb_arbiter dut (
    .clk(clk), .rst(rst),
    .alu_vld(alu_vld), .alu_rdy(alu_rdy),
    .alu_reg(alu_reg), .alu_data(alu_data),
    .ld_vld(ld_vld), .ld_rdy(ld_rdy),
    .ld_reg(ld_reg), .ld_data(ld_data),
    .pc_req(pc_req), .pc_next(pc_next),
    .pc_gnt(pc_gnt), .pc_drop(pc_drop),
    .src_reg(src_reg), .dst_reg(dst_reg),
    .rd_hazard(rd_hazard), .busy(busy),
    .wr_en(wr_en), .wr_reg(wr_reg),
    .wr_data(wr_data), .pc_inc(pc_inc),
    .pc_data_in(pc_data_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    pc_req = 1'b1;
    #3;
    n_chk++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL rst_wr_en got=%b exp=0", wr_en); end
    n_chk++; if (pc_inc !== 1'b0) begin n_fail++; $display("FAIL rst_pc_inc got=%b exp=0", pc_inc); end
    n_chk++; if (busy !== 16'h0) begin n_fail++; $display("FAIL rst_busy got=%h exp=0000", busy); end
    n_chk++; if ({alu_rdy, ld_rdy} !== 2'b11) begin n_fail++; $display("FAIL rst_rdy got=%b exp=11", {alu_rdy, ld_rdy}); end
    n_chk++; if (pc_gnt !== 1'b0) begin n_fail++; $display("FAIL rst_pc_gnt got=%b exp=0", pc_gnt); end
    pc_req = 1'b0;
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_single();
    alu_vld = 1'b1; alu_reg = 4'd5; alu_data = 16'h1234;
    src_reg = 4'd5; dst_reg = 4'd3;
    #1;
    n_chk++; if (alu_rdy !== 1'b1) begin n_fail++; $display("FAIL single_rdy got=%b exp=1", alu_rdy); end
    step();
    alu_vld = 1'b0;
    #1;
    n_chk++; if (busy !== 16'h0020) begin n_fail++; $display("FAIL single_busy got=%h exp=0020", busy); end
    n_chk++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL single_early got=%b exp=0", wr_en); end
    n_chk++; if (rd_hazard !== 1'b1) begin n_fail++; $display("FAIL single_haz got=%b exp=1", rd_hazard); end
    step();
    n_chk++; if ({wr_en, wr_reg, wr_data} !== {1'b1, 4'd5, 16'h1234}) begin n_fail++; $display("FAIL single_wr got=%b/%h/%h exp=1/5/1234", wr_en, wr_reg, wr_data); end
    n_chk++; if (busy !== 16'h0) begin n_fail++; $display("FAIL single_busy_clr got=%h exp=0000", busy); end
    step();
    n_chk++; if ({wr_en, wr_data} !== {1'b0, 16'h1234}) begin n_fail++; $display("FAIL single_hold got=%b/%h exp=0/1234", wr_en, wr_data); end
  endtask

  task automatic test_same_edge();
    alu_vld = 1'b1; alu_reg = 4'd4; alu_data = 16'h0001;
    ld_vld = 1'b1; ld_reg = 4'd4; ld_data = 16'h0002;
    step();
    alu_vld = 1'b0; ld_vld = 1'b0;
    #1;
    n_chk++; if (busy !== 16'h0010) begin n_fail++; $display("FAIL same_busy got=%h exp=0010", busy); end
    n_chk++; if ({alu_rdy, ld_rdy} !== 2'b10) begin n_fail++; $display("FAIL same_rdy got=%b exp=10", {alu_rdy, ld_rdy}); end
    step();
    n_chk++; if ({wr_en, wr_reg, wr_data} !== {1'b1, 4'd4, 16'h0001}) begin n_fail++; $display("FAIL same_first got=%b/%h/%h exp=1/4/0001", wr_en, wr_reg, wr_data); end
    n_chk++; if (busy !== 16'h0010) begin n_fail++; $display("FAIL same_busy_mid got=%h exp=0010", busy); end
    step();
    n_chk++; if ({wr_en, wr_reg, wr_data} !== {1'b1, 4'd4, 16'h0002}) begin n_fail++; $display("FAIL same_second got=%b/%h/%h exp=1/4/0002", wr_en, wr_reg, wr_data); end
    n_chk++; if (busy !== 16'h0) begin n_fail++; $display("FAIL same_busy_end got=%h exp=0000", busy); end
    step();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      alu_vld = 1'b1; alu_reg = 4'(i + 1); alu_data = 16'(16'h10 + i);
      #1;
      n_chk++; if (alu_rdy !== 1'b1) begin n_fail++; $display("FAIL b2b_rdy%0d got=%b exp=1", i, alu_rdy); end
      step();
      if (i > 0) begin
        n_chk++; if ({wr_en, wr_data} !== {1'b1, 16'(16'h10 + i - 1)}) begin n_fail++; $display("FAIL b2b_wr%0d got=%b/%h exp=1/%h", i, wr_en, wr_data, 16'h10 + i - 1); end
      end
    end
    alu_vld = 1'b0;
    step();
    n_chk++; if ({wr_en, wr_reg, wr_data} !== {1'b1, 4'd3, 16'h0012}) begin n_fail++; $display("FAIL b2b_last got=%b/%h/%h exp=1/3/0012", wr_en, wr_reg, wr_data); end
    step();
  endtask

  task automatic test_starve();
    ld_vld = 1'b1; ld_reg = 4'd9; ld_data = 16'hBEEF;
    step();
    ld_vld = 1'b0;
    pc_req = 1'b1; pc_next = 16'h0040;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_chk++; if (pc_gnt !== 1'b1) begin n_fail++; $display("FAIL starve_gnt%0d got=%b exp=1", i, pc_gnt); end
      step();
      n_chk++; if ({pc_inc, wr_en, pc_data_in} !== {2'b10, 16'(16'h40 + i)}) begin n_fail++; $display("FAIL starve_inc%0d got=%b%b/%h exp=10/%h", i, pc_inc, wr_en, pc_data_in, 16'h40 + i); end
      pc_next = 16'(16'h41 + i);
    end
    #1;
    n_chk++; if (pc_gnt !== 1'b0) begin n_fail++; $display("FAIL starve_block got=%b exp=0", pc_gnt); end
    n_chk++; if (busy !== 16'h0200) begin n_fail++; $display("FAIL starve_busy got=%h exp=0200", busy); end
    step();
    n_chk++; if ({wr_en, pc_inc, wr_reg, wr_data} !== {2'b10, 4'd9, 16'hBEEF}) begin n_fail++; $display("FAIL starve_wr got=%b%b/%h/%h exp=10/9/beef", wr_en, pc_inc, wr_reg, wr_data); end
    #1;
    n_chk++; if (pc_gnt !== 1'b1) begin n_fail++; $display("FAIL starve_resume got=%b exp=1", pc_gnt); end
    step();
    pc_req = 1'b0;
    n_chk++; if ({pc_inc, wr_en, pc_data_in} !== {2'b10, 16'h0043}) begin n_fail++; $display("FAIL starve_inc3 got=%b%b/%h exp=10/0043", pc_inc, wr_en, pc_data_in); end
    step();
  endtask

  task automatic test_pc_drop();
    alu_vld = 1'b1; alu_reg = 4'd0; alu_data = 16'h0100;
    step();
    alu_vld = 1'b0;
    pc_req = 1'b1; pc_next = 16'h0040;
    #1;
    n_chk++; if ({pc_drop, pc_gnt} !== 2'b10) begin n_fail++; $display("FAIL drop_pulse got=%b%b exp=10", pc_drop, pc_gnt); end
    n_chk++; if (busy !== 16'h0001) begin n_fail++; $display("FAIL drop_busy got=%h exp=0001", busy); end
    step();
    pc_req = 1'b0;
    n_chk++; if ({wr_en, pc_inc, wr_reg, wr_data} !== {2'b10, 4'd0, 16'h0100}) begin n_fail++; $display("FAIL drop_wr got=%b%b/%h/%h exp=10/0/0100", wr_en, pc_inc, wr_reg, wr_data); end
    n_chk++; if (pc_data_in !== 16'h0043) begin n_fail++; $display("FAIL drop_pc_hold got=%h exp=0043", pc_data_in); end
    #1;
    n_chk++; if (pc_drop !== 1'b0) begin n_fail++; $display("FAIL drop_end got=%b exp=0", pc_drop); end
    step();
  endtask

  task automatic test_hazard();
    ld_vld = 1'b1; ld_reg = 4'd7; ld_data = 16'h7777;
    src_reg = 4'd7; dst_reg = 4'd0;
    #1;
    n_chk++; if (rd_hazard !== 1'b0) begin n_fail++; $display("FAIL haz_pre got=%b exp=0", rd_hazard); end
    step();
    ld_vld = 1'b0;
    pc_req = 1'b1; pc_next = 16'h0050;
    #1;
    n_chk++; if ({rd_hazard, pc_gnt} !== 2'b11) begin n_fail++; $display("FAIL haz_src got=%b%b exp=11", rd_hazard, pc_gnt); end
    step();
    pc_req = 1'b0;
    src_reg = 4'd2; dst_reg = 4'd7;
    #1;
    n_chk++; if (rd_hazard !== 1'b1) begin n_fail++; $display("FAIL haz_dst got=%b exp=1", rd_hazard); end
    step();
    n_chk++; if ({wr_en, wr_reg, rd_hazard} !== {1'b1, 4'd7, 1'b0}) begin n_fail++; $display("FAIL haz_clr got=%b/%h/%b exp=1/7/0", wr_en, wr_reg, rd_hazard); end
    step();
  endtask

  task automatic test_reset_mid();
    alu_vld = 1'b1; alu_reg = 4'd1; alu_data = 16'hAAAA;
    ld_vld = 1'b1; ld_reg = 4'd2; ld_data = 16'hBBBB;
    step();
    alu_vld = 1'b0; ld_vld = 1'b0;
    step();
    n_chk++; if ({wr_en, busy} !== {1'b1, 16'h0004}) begin n_fail++; $display("FAIL mid_pre got=%b/%h exp=1/0004", wr_en, busy); end
    rst = 1'b0;
    #1;
    n_chk++; if ({wr_en, pc_inc} !== 2'b00) begin n_fail++; $display("FAIL mid_strobe got=%b%b exp=00", wr_en, pc_inc); end
    n_chk++; if (busy !== 16'h0) begin n_fail++; $display("FAIL mid_busy got=%h exp=0000", busy); end
    n_chk++; if ({alu_rdy, ld_rdy} !== 2'b11) begin n_fail++; $display("FAIL mid_rdy got=%b exp=11", {alu_rdy, ld_rdy}); end
    step();
    rst = 1'b1;
    step();
    step();
    n_chk++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL mid_dropped got=%b exp=0", wr_en); end
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    rst = 1'b0;
    alu_vld = 1'b0; alu_reg = '0; alu_data = '0;
    ld_vld = 1'b0; ld_reg = '0; ld_data = '0;
    pc_req = 1'b0; pc_next = '0;
    src_reg = '0; dst_reg = '0;
    test_reset();
    test_single();
    test_same_edge();
    test_back_to_back();
    test_starve();
    test_pc_drop();
    test_hazard();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
